// File: rtl/riscv_instr_port_arbiter.sv
// Purpose: two-requester instruction port arbiter with in-order response routing via an owner FIFO.
// Latency: requests and responses pass through combinationally, with zero added cycles.
// Backpressure: the memory stalls a request by holding gnt low, which locks the selection. Requests are masked while MAX_OUTSTANDING are in flight.
//
// Ports:
//   clk, rst                     - clock; synchronous active-high reset
//   m0_* / m1_*                  - fetch (prefetch buffer) and debug requesters: req/addr in, gnt/rvalid out
//   m_rdata_o                    - shared read data, qualified by the per-requester rvalid
//   instr_req_o/addr_o/gnt_i     - memory-side request channel
//   instr_rvalid_i/rdata_i       - memory-side in-order response channel
//   busy_o                       - at least one transaction outstanding
//   err_o                        - sticky flag: a response arrived with nothing outstanding

// Purpose: generic synchronous FIFO with wrap-around pointers and an occupancy counter.
// Latency: a written entry is visible at rd_dat on the cycle after the push; rd_dat shows the head combinationally.
// Backpressure: a push while full and a pop while empty are ignored. Push and pop in the same cycle keep the count unchanged.
module simple_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage carries no reset: an entry is only read after the count says it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap at DEPTH rather than at a power of two, so any depth works.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module riscv_instr_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m_rdata_o,
    output logic                  instr_req_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0] instr_rdata_i,
    output logic                  busy_o,
    output logic                  err_o
);
    logic last_winner;   // 0 = m0 won the last handshake, 1 = m1
    logic lock;          // a request was presented but not granted last cycle
    logic lock_id;       // requester that owns the stalled request
    logic sel;           // requester currently presented to memory
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic head;
    logic err;

    // A stalled request keeps ownership while its requester holds req. This keeps
    // the address stable until grant. Otherwise a tie goes to the requester that
    // did not win last.
    always_comb begin
        sel = 1'b0;
        if (lock && (lock_id ? m1_req_i : m0_req_i)) begin
            sel = lock_id;
        end else if (m0_req_i && m1_req_i) begin
            sel = ~last_winner;
        end else if (m1_req_i) begin
            sel = 1'b1;
        end
    end

    assign instr_req_o  = (m0_req_i | m1_req_i) & ~full;
    assign instr_addr_o = sel ? m1_addr_i : m0_addr_i;

    assign push     = instr_req_o & instr_gnt_i;
    assign m0_gnt_o = push & ~sel;
    assign m1_gnt_o = push & sel;

    // Responses with nothing outstanding are dropped here and flagged via err.
    assign pop         = instr_rvalid_i & ~empty;
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m_rdata_o   = instr_rdata_i;

    assign busy_o = ~empty;
    assign err_o  = err;

    simple_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_dat (sel),
        .pop    (pop),
        .rd_dat (head),
        .full   (full),
        .empty  (empty)
    );

    // last_winner resets to 1 so that m0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= 1'b1;
            lock        <= 1'b0;
            lock_id     <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (push) begin
                last_winner <= sel;
            end
            lock    <= instr_req_o & ~instr_gnt_i;
            lock_id <= sel;
            if (instr_rvalid_i && empty) begin
                err <= 1'b1;
            end
        end
    end
endmodule
